// File: rtl/alu_ctrl_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_muldiv
//  Description : EX-stage ALU control decode with an iterative multiply/divide
//                sequencer that owns the HI/LO registers. Stalls HI/LO ops
//                while the sequencer is busy.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       AluOp,
   input  logic [5:0]       Func,
   input  logic             Issue,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [2:0]       AluCtrl,
   output logic             IllegalOp,
   output logic             MdBusy,
   output logic             Stall,
   output logic             MdRead,
   output logic [WIDTH-1:0] MdResult,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int               CNT_W      = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [5:0] c_F_MFHI = 6'b010000;
   localparam logic [5:0] c_F_MTHI = 6'b010001;
   localparam logic [5:0] c_F_MFLO = 6'b010010;
   localparam logic [5:0] c_F_MTLO = 6'b010011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_acc_hi;   // partial product high half / remainder
   logic [WIDTH-1:0]   r_acc_lo;   // multiplier bits / dividend-quotient
   logic [WIDTH-1:0]   r_b;        // multiplicand / divisor magnitude
   logic [WIDTH-1:0]   r_a_raw;    // SrcA as latched, for divide-by-zero
   logic               r_is_div;
   logic               r_neg_q;    // negate product or quotient
   logic               r_neg_r;    // negate remainder
   logic               r_dz;
   logic               r_busy;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic [2:0]         w_ctrl;
   logic               w_ill;
   logic               w_md_op;
   logic               w_is_mf;
   logic               w_accept;
   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_div_shift;
   logic [WIDTH:0]     w_div_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   // ALU control decode; HI/LO functs are recognised as MD ops
   always_comb begin
      w_ctrl  = 3'b010;
      w_ill   = 1'b0;
      w_md_op = 1'b0;
      case (AluOp)
         2'b00: w_ctrl = 3'b010;
         2'b01: w_ctrl = 3'b110;
         2'b10: begin
            case (Func)
               6'b100000: w_ctrl = 3'b010;
               6'b100010: w_ctrl = 3'b110;
               6'b100100: w_ctrl = 3'b000;
               6'b100101: w_ctrl = 3'b001;
               6'b100111: w_ctrl = 3'b011;
               6'b101010: w_ctrl = 3'b111;
               6'b101011: w_ctrl = 3'b101;
               6'b010000, 6'b010001, 6'b010010, 6'b010011,
               6'b011000, 6'b011001, 6'b011010, 6'b011011: w_md_op = 1'b1;
               default:   w_ill = 1'b1;
            endcase
         end
         default: w_ill = 1'b1;
      endcase
   end

   assign AluCtrl   = w_ctrl;
   assign IllegalOp = w_ill;

   assign w_is_mf  = w_md_op & ((Func == c_F_MFHI) | (Func == c_F_MFLO));
   assign Stall    = Issue & w_md_op & r_busy;
   assign w_accept = Issue & w_md_op & ~r_busy;
   assign MdRead   = w_is_mf & ~Stall;
   assign MdResult = (Func == c_F_MFHI) ? r_hi : r_lo;
   assign MdBusy   = r_busy;
   assign Hi       = r_hi;
   assign Lo       = r_lo;

   // Funct bit 0 set selects the unsigned variant
   assign w_signed = ~Func[0];
   assign w_a_neg  = w_signed & SrcA[WIDTH-1];
   assign w_b_neg  = w_signed & SrcB[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -SrcA : SrcA;
   assign w_b_mag  = w_b_neg ? -SrcB : SrcB;

   // Shift-add: conditionally add multiplicand, then shift {hi,lo} right
   assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

   // Restoring divide: shift next dividend bit into remainder, trial subtract
   assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_b};

   // Sign correction applied on the FIX edge
   assign w_prod     = {r_acc_hi, r_acc_lo};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
   assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

   // Sequencer FSM, iteration datapath and HI/LO registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_acc_hi <= '0;
         r_acc_lo <= '0;
         r_b      <= '0;
         r_a_raw  <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (Func == c_F_MTHI) r_hi <= SrcA;
                  if (Func == c_F_MTLO) r_lo <= SrcA;
                  if (Func[5:2] == 4'b0110) begin
                     r_state  <= Func[1] ? S_DIV : S_MUL;
                     r_busy   <= 1'b1;
                     r_cnt    <= '0;
                     r_is_div <= Func[1];
                     r_acc_hi <= '0;
                     r_acc_lo <= w_a_mag;
                     r_b      <= w_b_mag;
                     r_a_raw  <= SrcA;
                     r_neg_q  <= w_a_neg ^ w_b_neg;
                     r_neg_r  <= w_a_neg;
                     r_dz     <= (SrcB == '0);
                  end
               end
            end
            S_MUL: begin
               r_acc_hi <= w_mul_sum[WIDTH:1];
               r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
               if (r_cnt == c_CNT_LAST) r_state <= S_FIX;
               else                     r_cnt   <= r_cnt + CNT_W'(1);
            end
            S_DIV: begin
               r_acc_hi <= w_div_diff[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
               r_acc_lo <= {r_acc_lo[WIDTH-2:0], ~w_div_diff[WIDTH]};
               if (r_cnt == c_CNT_LAST) r_state <= S_FIX;
               else                     r_cnt   <= r_cnt + CNT_W'(1);
            end
            S_FIX: begin
               if (!r_is_div) begin
                  r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_fix[WIDTH-1:0];
               end else if (r_dz) begin
                  r_hi <= r_a_raw;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_muldiv
//  Description : Self-checking bench for alu_ctrl_muldiv; directed scenarios
//                plus randomized traffic against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_muldiv;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk;
   logic          rst_n;
   logic [1:0]    AluOp;
   logic [5:0]    Func;
   logic          Issue;
   logic [W-1:0]  SrcA;
   logic [W-1:0]  SrcB;
   logic [2:0]    AluCtrl;
   logic          IllegalOp;
   logic          MdBusy;
   logic          Stall;
   logic          MdRead;
   logic [W-1:0]  MdResult;
   logic [W-1:0]  Hi;
   logic [W-1:0]  Lo;

   alu_ctrl_muldiv #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .AluOp     (AluOp),
      .Func      (Func),
      .Issue     (Issue),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .AluCtrl   (AluCtrl),
      .IllegalOp (IllegalOp),
      .MdBusy    (MdBusy),
      .Stall     (Stall),
      .MdRead    (MdRead),
      .MdResult  (MdResult),
      .Hi        (Hi),
      .Lo        (Lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // reference model state: architectural HI/LO, pending result, cycles left
   logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
   int           m_left;

   // last sampled outputs, for directed checks
   logic         s_stall, s_rd, s_ill;
   logic [2:0]   s_ctrl;
   logic [W-1:0] s_res;

   logic [5:0] fn_pool [0:16] = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                  6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h3F};
   logic [W-1:0] opd_pool [0:6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                    32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE};

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                      output logic [2:0] ctrl, output logic ill, output logic md);
      ctrl = 3'b010;
      ill  = 1'b0;
      md   = 1'b0;
      if (op == 2'b01) ctrl = 3'b110;
      else if (op == 2'b11) ill = 1'b1;
      else if (op == 2'b10) begin
         case (fn)
            6'h20: ctrl = 3'b010;
            6'h22: ctrl = 3'b110;
            6'h24: ctrl = 3'b000;
            6'h25: ctrl = 3'b001;
            6'h27: ctrl = 3'b011;
            6'h2A: ctrl = 3'b111;
            6'h2B: ctrl = 3'b101;
            6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: md = 1'b1;
            default: ill = 1'b1;
         endcase
      end
   endfunction

   // HI/LO result of mult/multu/div/divu computed with plain arithmetic
   function automatic void ref_md(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (fn)
         6'h18: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
         6'h19: begin p = {32'h0, a} * {32'h0, b}; h = p[63:32]; l = p[31:0]; end
         default: begin
            if (b == 0) begin
               h = a;
               l = 32'hFFFF_FFFF;
            end else if (fn == 6'h1A) begin
               q = sa / sb;
               r = sa % sb;
               h = r[31:0];
               l = q[31:0];
            end else begin
               h = a % b;
               l = a / b;
            end
         end
      endcase
   endfunction

   // one clock: drive at negedge, check before the edge, advance the model
   task automatic step(input logic [1:0] op, input logic [5:0] fn, input logic iss,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic rn);
      logic [2:0]   e_ctrl;
      logic         e_ill, e_md, e_busy, e_stall, e_rd;
      logic [W-1:0] nh, nl;
      AluOp = op; Func = fn; Issue = iss; SrcA = a; SrcB = b; rst_n = rn;
      #1;
      ref_decode(op, fn, e_ctrl, e_ill, e_md);
      e_busy  = (m_left > 0);
      e_stall = iss & e_md & e_busy;
      e_rd    = e_md & ((fn == 6'h10) | (fn == 6'h12)) & ~e_stall;
      check_val("aluctrl", AluCtrl, e_ctrl);
      check_val("illegal", IllegalOp, e_ill);
      check_val("busy", MdBusy, e_busy);
      check_val("stall", Stall, e_stall);
      check_val("mdread", MdRead, e_rd);
      check_val("hi", Hi, m_hi);
      check_val("lo", Lo, m_lo);
      if (e_rd) check_val("mdresult", MdResult, (fn == 6'h10) ? m_hi : m_lo);
      s_stall = Stall; s_rd = MdRead; s_res = MdResult; s_ctrl = AluCtrl; s_ill = IllegalOp;
      @(posedge clk);
      if (!rn) begin
         m_hi = '0; m_lo = '0; m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (iss && e_md) begin
         case (fn)
            6'h11: m_hi = a;
            6'h13: m_lo = a;
            6'h18, 6'h19, 6'h1A, 6'h1B: begin
               ref_md(fn, a, b, nh, nl);
               m_phi = nh; m_plo = nl; m_left = LAT;
            end
            default: ;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic nop();
      step(2'b00, 6'h00, 1'b0, '0, '0, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while (MdBusy === 1'b1 && n < 100) begin nop(); n++; end
      check_val("drain_idle", MdBusy, 1'b0);
   endtask

   task automatic run_md(input string tag, input logic [5:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
      int n = 0;
      step(2'b10, fn, 1'b1, a, b, 1'b1);
      while (MdBusy === 1'b1 && n < 100) begin nop(); n++; end
      check_val({tag, "_cycles"}, n, LAT);
      check_val({tag, "_hi"}, Hi, eh);
      check_val({tag, "_lo"}, Lo, el);
   endtask

   initial begin
      int n, rd_in_stall;
      logic [1:0]   op;
      logic [5:0]   fn;
      logic [W-1:0] a, b;
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_left = 0;
      rst_n = 1'b0; AluOp = 2'b00; Func = 6'h00; Issue = 1'b0; SrcA = '0; SrcB = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_busy", MdBusy, 1'b0);
      check_val("rst_hi", Hi, 32'h0);
      check_val("rst_lo", Lo, 32'h0);

      // decode sweep
      for (int i = 0; i < 17; i++) step(2'b10, fn_pool[i], 1'b0, '0, '0, 1'b1);
      step(2'b10, 6'h00, 1'b0, '0, '0, 1'b1);
      check_val("ill_f00", s_ill, 1'b1);
      step(2'b11, 6'h20, 1'b0, '0, '0, 1'b1);
      check_val("ill_op11", s_ill, 1'b1);
      step(2'b01, 6'h20, 1'b0, '0, '0, 1'b1);
      check_val("op01_sub", s_ctrl, 3'b110);
      step(2'b10, 6'h2B, 1'b0, '0, '0, 1'b1);
      check_val("sltu", s_ctrl, 3'b101);

      // arithmetic corner cases
      run_md("mult",   6'h18, 32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_md("multu",  6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_md("div",    6'h1A, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divmin", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
      run_md("divu0",  6'h1B, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF);
      run_md("div0s",  6'h1A, 32'h8765_4321, 32'h0,         32'h8765_4321, 32'hFFFF_FFFF);

      // hazard: mflo right behind a mult
      step(2'b10, 6'h18, 1'b1, 32'h7, 32'hFFFF_FFFD, 1'b1);
      n = 0; rd_in_stall = 0;
      step(2'b10, 6'h12, 1'b1, '0, '0, 1'b1);
      while (s_stall === 1'b1 && n < 100) begin
         if (s_rd !== 1'b0) rd_in_stall++;
         n++;
         step(2'b10, 6'h12, 1'b1, '0, '0, 1'b1);
      end
      check_val("haz_stalls", n, LAT);
      check_val("haz_rd_in_stall", rd_in_stall, 0);
      check_val("haz_rd", s_rd, 1'b1);
      check_val("haz_res", s_res, 32'hFFFF_FFEB);

      // non-MD op during busy never stalls; a flush does not abort
      step(2'b10, 6'h19, 1'b1, 32'h3, 32'h5, 1'b1);
      step(2'b10, 6'h20, 1'b1, '0, '0, 1'b1);
      check_val("add_busy_stall", s_stall, 1'b0);
      check_val("add_busy_ctrl", s_ctrl, 3'b010);
      drain();
      check_val("flush_lo", Lo, 32'hF);

      // reset in the middle of a divide
      step(2'b10, 6'h1A, 1'b1, 32'h64, 32'h7, 1'b1);
      repeat (9) nop();
      step(2'b00, 6'h00, 1'b0, '0, '0, 1'b0);
      check_val("midrst_busy", MdBusy, 1'b0);
      check_val("midrst_hi", Hi, 32'h0);
      check_val("midrst_lo", Lo, 32'h0);
      step(2'b10, 6'h11, 1'b1, 32'hA5A5_A5A5, '0, 1'b1);
      step(2'b10, 6'h10, 1'b1, '0, '0, 1'b1);
      check_val("mfhi", s_res, 32'hA5A5_A5A5);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         op = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom_range(0, 3));
         fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 16)];
         a  = ($urandom_range(0, 1) == 0) ? W'($urandom) : opd_pool[$urandom_range(0, 6)];
         b  = ($urandom_range(0, 1) == 0) ? W'($urandom) : opd_pool[$urandom_range(0, 6)];
         step(op, fn, ($urandom_range(0, 3) != 0), a, b, ($urandom_range(0, 499) != 0));
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_muldiv.md
Name: alu_ctrl_muldiv

Overview:
Parametrised successor to the single-cycle ALU control decoder for the MIPS datapath. It performs the combinational ALU-control decode, extended with nor and sltu, and an illegal-op flag. It also adds an iterative multiply/divide sequencer that owns the HI/LO registers. It sits in the EX stage and drives the pipeline stall when a HI/LO-dependent instruction meets a busy sequencer.

Parameters:
WIDTH, 32, datapath width of SrcA/SrcB/HI/LO (even, >=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
AluOp  input  2  main-control ALU op class
Func  input  6  instruction funct field
Issue  input  1  EX instruction valid and not flushed
SrcA  input  WIDTH  rs operand
SrcB  input  WIDTH  rt operand
AluCtrl  output  3  ALU operation select (combinational)
IllegalOp  output  1  undecodable AluOp/Func (combinational)
MdBusy  output  1  sequencer running
Stall  output  1  hold pipeline (combinational)
MdRead  output  1  current op is mfhi/mflo, select MdResult for writeback
MdResult  output  WIDTH  HI (mfhi) or LO (mflo), combinational mux of registers
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset: one clock is fixed and reset is synchronous active-low. rst_n low at a rising edge sets FSM=IDLE, MdBusy=0, Hi=0, Lo=0 and counter=0. Reset mid-operation aborts with no partial HI/LO update.
- AluCtrl decode:
  - AluOp 00 -> 010 (add).
  - AluOp 01 -> 110 (sub).
  - AluOp 10, by Func: 100000 add -> 010; 100010 sub -> 110; 100100 and -> 000; 100101 or -> 001; 100111 nor -> 011; 101010 slt -> 111; 101011 sltu -> 101.
  - AluOp 10, Func 010000/010001/010010/010011/011000/011001/011010/011011 (mfhi, mthi, mflo, mtlo, mult, multu, div, divu) -> 010, IllegalOp=0.
  - Any other combination, including AluOp 11 -> AluCtrl=010, IllegalOp=1.
  - The decode outputs do not depend on Issue.
- MD op = AluOp 10 with one of the eight HI/LO funct codes.
- Stall = Issue & MD op & MdBusy. A stalled op is not accepted; it is re-presented next cycle.
- Accept = Issue & MD op & !MdBusy.
- mthi/mtlo: on accept, Hi (or Lo) <= SrcA at that edge. Single cycle, no busy.
- mfhi/mflo: MdRead=1, MdResult=Hi/Lo combinationally when not stalled. Stall forces MdRead=0.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE -> MUL on mult/multu accept; IDLE -> DIV on div/divu accept.
  - On accept, latch operand magnitudes (two's-complement absolute value when signed), sign flags and counter=0.
  - MUL/DIV run one shift-add or restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to FIX.
  - FIX applies the sign correction, writes Hi/Lo, then returns to IDLE.
  - MdBusy=1 in MUL, DIV and FIX. Hi/Lo update on the FIX edge. A new MD op is accepted the cycle after FIX, so latency is WIDTH+1 cycles from the accept edge.
- Multiply result: {Hi,Lo} = 2*WIDTH-bit product. For signed ops the product is negated when the operand signs differ.
- Divide result: Lo = quotient, Hi = remainder.
  - Signed: quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Signed MIN / -1 -> Lo=MIN, Hi=0 (wraps).
  - Divide by zero (signed or unsigned) -> Lo = all ones, Hi = SrcA as latched. No exception.
- Issue dropped mid-operation (flush) does not abort the running op.
- A non-MD instruction never stalls, even while busy.
- Counter does not wrap: it saturates at WIDTH-1 before FIX.

Test Plan:
- Decode sweep: every AluOp/Func listed -> the AluCtrl code stated above with IllegalOp=0; Func 000000 with AluOp 10 -> IllegalOp=1; AluOp 11 -> IllegalOp=1.
- mult signed: SrcA=7, SrcB=FFFFFFFD -> after 33 cycles Hi=FFFFFFFF, Lo=FFFFFFEB; MdBusy high for exactly 33 cycles.
- multu: FFFFFFFF x FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001. div: FFFFFFF9 / 2 -> Lo=FFFFFFFD, Hi=FFFFFFFF. div: 80000000 / FFFFFFFF -> Lo=80000000, Hi=0.
- divu by zero: SrcA=12345678, SrcB=0 -> Lo=FFFFFFFF, Hi=12345678.
- Hazard: mflo issued the cycle after mult accept -> Stall=1 and MdRead=0 for 33 cycles, then MdRead=1 with MdResult=new Lo. An add issued during busy -> Stall=0, AluCtrl=010.
- Reset mid-op: rst_n low at cycle 10 of div -> next cycle MdBusy=0, Hi=Lo=0. mthi SrcA=A5A5A5A5 then mfhi -> MdResult=A5A5A5A5.
